icache_direct: RTL and testbench

- Direct-mapped, one-word-per-block instruction cache for one core.
- Sits directly upstream of the memory/coherence controller.
- Serves fetch requests from the datapath. On a miss, issues single-word instruction reads on that core's iREN/iaddr lane and consumes iload/iwait.
- Provides flush and hit/miss performance counters.

---
 rtl/icache_direct.sv | 124 ++++++++++++
 tb/tb_icache_direct.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss, whole-cache flush and saturating hit/miss counters.
module icache_direct #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [31:0]      hit_count_q, hit_count_d;
  logic [31:0]      miss_count_q, miss_count_d;

  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill;
  logic             unused_addr_bits;

  assign req_idx          = imemaddr[IDX_W+1:2];
  assign req_tag          = imemaddr[31:IDX_W+2];
  assign fill_idx         = miss_addr_q[IDX_W+1:2];
  assign fill_tag         = miss_addr_q[31:IDX_W+2];
  assign unused_addr_bits = ^{imemaddr[1:0], miss_addr_q[1:0]};

  always_comb begin
    hit  = (state_q == IDLE) && imemREN && valid_q[req_idx]
           && (tag_q[req_idx] == req_tag);
    fill = (state_q == FETCH) && !iwait;
  end

  always_comb begin
    ihit     = hit;
    imemload = hit ? data_q[req_idx] : '0;
    iREN     = (state_q == FETCH);
    iaddr    = (state_q == FETCH) ? miss_addr_q : '0;
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          state_d     = FETCH;
          miss_addr_d = {imemaddr[31:2], 2'b00};
        end
      end
      FETCH: begin
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush takes priority over a coincident fill, leaving the new line invalid.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (fill) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != '1)) hit_count_d = hit_count_q + 32'd1;
    if ((state_q == IDLE) && (state_d == FETCH) && (miss_count_q != '1))
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct (SETS=16): miss/fill timing, conflicts,
// mid-fill address change, flush interactions, reset mid-fill, saturation.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests  = 0;
  int failed = 0;

  icache_direct #(.SETS(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .imemload  (imemload),
    .ihit      (ihit),
    .flush     (flush),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iload     (iload),
    .iwait     (iwait),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Starts in IDLE at a negedge; ends in IDLE at a negedge with the hit
  // checked combinationally and imemREN dropped before the next edge.
  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    #1 chk("miss_ihit", {31'b0, ihit}, 32'd0);
    step();
    for (int i = 0; i < nwait; i++) begin
      chk("fetch_iren", {31'b0, iREN}, 32'd1);
      chk("fetch_iaddr", iaddr, addr);
      step();
    end
    iwait = 1'b0; iload = data;
    #1 chk("fetch_iren_last", {31'b0, iREN}, 32'd1);
    chk("fetch_iaddr_last", iaddr, addr);
    step();
    iwait = 1'b1;
    #1 chk("fill_ihit", {31'b0, ihit}, 32'd1);
    chk("fill_imemload", imemload, data);
    imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    iload = '0; iwait = 1'b1;
    step(); step();
    RST = 1'b0;
    #1 chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);

    // Basic miss: 3 FETCH cycles, then a hit cycle.
    miss_fill(32'h40, 32'h8C220004, 2);
    imemREN = 1'b1;
    step();
    imemREN = 1'b0;
    #1 chk("t1_hits", hit_count, 32'd1);
    chk("t1_misses", miss_count, 32'd1);

    // Conflict at index 0: 0x0 evicts 0x40, 0x40 evicts 0x0.
    miss_fill(32'h0, 32'h11111111, 0);
    miss_fill(32'h40, 32'h22222222, 1);
    imemREN = 1'b1; imemaddr = 32'h0;
    #1 chk("t2_rerequest_0", {31'b0, ihit}, 32'd0);
    imemaddr = 32'h43;
    #1 chk("t2_40_hit_offset", {31'b0, ihit}, 32'd1);
    chk("t2_40_data", imemload, 32'h22222222);
    imemREN = 1'b0;
    #1 chk("t2_hits", hit_count, 32'd1);
    chk("t2_misses", miss_count, 32'd3);

    // Address changes while the fill for 0x100 is stalled.
    imemREN = 1'b1; imemaddr = 32'h100;
    step();
    imemaddr = 32'h200;
    #1 chk("t3_iaddr_a", iaddr, 32'h100);
    step();
    chk("t3_iaddr_b", iaddr, 32'h100);
    iwait = 1'b0; iload = 32'h33333333;
    step();
    iwait = 1'b1;
    imemaddr = 32'h100;
    #1 chk("t3_100_hit", {31'b0, ihit}, 32'd1);
    chk("t3_100_data", imemload, 32'h33333333);
    imemaddr = 32'h200;
    #1 chk("t3_200_miss", {31'b0, ihit}, 32'd0);
    step();
    chk("t3_iaddr_200", iaddr, 32'h200);
    iwait = 1'b0; iload = 32'h44444444;
    step();
    iwait = 1'b1; imemREN = 1'b0;
    #1 chk("t3_hits", hit_count, 32'd1);
    chk("t3_misses", miss_count, 32'd5);

    // Flush coincident with fill completion for 0x80.
    miss_fill(32'h8, 32'h55555555, 0);
    imemREN = 1'b1; imemaddr = 32'h80;
    step();
    iwait = 1'b0; iload = 32'h66666666; flush = 1'b1;
    step();
    iwait = 1'b1; flush = 1'b0;
    #1 chk("t4_iren_idle", {31'b0, iREN}, 32'd0);
    chk("t4_80_miss", {31'b0, ihit}, 32'd0);
    imemaddr = 32'h8;
    #1 chk("t4_8_miss", {31'b0, ihit}, 32'd0);
    imemaddr = 32'h200;
    #1 chk("t4_200_miss", {31'b0, ihit}, 32'd0);
    imemREN = 1'b0;

    // Flush in IDLE still reports the hit from pre-flush contents.
    miss_fill(32'h8, 32'h55555555, 0);
    imemREN = 1'b1; imemaddr = 32'h8; flush = 1'b1;
    #1 chk("t4_flush_hit", {31'b0, ihit}, 32'd1);
    step();
    flush = 1'b0;
    #1 chk("t4_after_flush", {31'b0, ihit}, 32'd0);
    imemREN = 1'b0;
    #1 chk("t4_hits", hit_count, 32'd2);
    chk("t4_misses", miss_count, 32'd8);

    // Reset while fetching, with the fill data arriving on the reset edge.
    imemREN = 1'b1; imemaddr = 32'h300;
    step();
    chk("t5_iren_fetch", {31'b0, iREN}, 32'd1);
    RST = 1'b1; iwait = 1'b0; iload = 32'h77777777;
    step();
    RST = 1'b0; iwait = 1'b1; imemREN = 1'b0;
    #1 chk("t5_iren", {31'b0, iREN}, 32'd0);
    chk("t5_iaddr", iaddr, 32'd0);
    chk("t5_hits", hit_count, 32'd0);
    chk("t5_misses", miss_count, 32'd0);
    imemREN = 1'b1;
    #1 chk("t5_300_miss", {31'b0, ihit}, 32'd0);
    imemREN = 1'b0;

    // Hit counter saturation.
    miss_fill(32'h4, 32'h88888888, 0);
    imemREN = 1'b1;
    force dut.hit_count_q = 32'hFFFFFFFE;
    #1 release dut.hit_count_q;
    #1 chk("t6_preset", hit_count, 32'hFFFFFFFE);
    step();
    chk("t6_hit1", hit_count, 32'hFFFFFFFF);
    step();
    chk("t6_hit2", hit_count, 32'hFFFFFFFF);
    step();
    chk("t6_hit3", hit_count, 32'hFFFFFFFF);
    chk("t6_misses", miss_count, 32'd1);
    imemREN = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
